// File: rtl/alu_reg.sv
// alu_reg: 32-bit integer ALU with registered result and status flags.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst      - asynchronous, active-high reset
//   data1    - operand A (rs)
//   data2    - operand B (rt or immediate); [4:0] is the shift amount
//   ALUop    - 4-bit operation select
//   result   - registered operation result (valid one cycle after inputs)
//   zero     - registered; 1 when the registered result is 0
//   overflow - registered; signed overflow of ADD/SUB, otherwise 0
module alu_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [3:0]  ALUop,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLTU = 4'b0100,
    OP_PASB = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_LUI  = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_MUL  = 4'b1101,
    OP_SEQ  = 4'b1110,
    OP_RSVD = 4'b1111
  } op_e;

  op_e         op;
  logic [4:0]  sh;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] res_n;
  logic        ovf_n;

  assign op   = op_e'(ALUop);
  assign sh   = data2[4:0];
  assign sum  = data1 + data2;
  assign diff = data1 - data2;

  always_comb begin
    res_n = '0;
    ovf_n = 1'b0;
    case (op)
      OP_AND:  res_n = data1 & data2;
      OP_OR:   res_n = data1 | data2;
      OP_ADD: begin
        res_n = sum;
        // Same-sign operands producing a different-sign sum.
        ovf_n = (data1[31] == data2[31]) && (sum[31] != data1[31]);
      end
      OP_XOR:  res_n = data1 ^ data2;
      OP_SLTU: res_n = {31'd0, (data1 < data2)};
      OP_PASB: res_n = data2;
      OP_SUB: begin
        res_n = diff;
        // Opposite-sign operands where the difference loses A's sign.
        ovf_n = (data1[31] != data2[31]) && (diff[31] != data1[31]);
      end
      OP_SLT:  res_n = {31'd0, ($signed(data1) < $signed(data2))};
      OP_SLL:  res_n = data1 << sh;
      OP_SRL:  res_n = data1 >> sh;
      OP_SRA:  res_n = 32'($signed(data1) >>> sh);
      OP_LUI:  res_n = {data2[15:0], 16'h0000};
      OP_NOR:  res_n = ~(data1 | data2);
      OP_MUL:  res_n = 32'(data1 * data2);
      OP_SEQ:  res_n = {31'd0, (data1 == data2)};
      OP_RSVD: res_n = '0;
      default: res_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      result   <= res_n;
      zero     <= (res_n == '0);
      overflow <= ovf_n;
    end
  end

endmodule

// File: tb/tb_alu_reg.sv
module tb_alu_reg;

  logic        clk;
  logic        rst;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [3:0]  ALUop;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int unsigned total;
  int unsigned bad;

  alu_reg dut (
    .clk      (clk),
    .rst      (rst),
    .data1    (data1),
    .data2    (data2),
    .ALUop    (ALUop),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] er, input logic ez, input logic eo);
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [31:0] er, input logic ez,
                      input logic eo);
    data1 = a;
    data2 = b;
    ALUop = op;
    @(posedge clk);
    #1;
    check_all(tag, er, ez, eo);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset asserted with ADD inputs present, checked before any edge.
    rst   = 1'b1;
    data1 = 32'd5;
    data2 = 32'd7;
    ALUop = 4'b0010;
    #2;
    check_all("reset", 32'd0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("first_add", 32'd12, 1'b0, 1'b0);

    // Back-to-back sequence
    step("seq_sll", 32'd1, 32'd2, 4'b1000, 32'd4, 1'b0, 1'b0);
    step("seq_add", 32'd4, 32'd3, 4'b0010, 32'd7, 1'b0, 1'b0);
    step("seq_mul", 32'd1, 32'd2, 4'b1101, 32'd2, 1'b0, 1'b0);

    // Arithmetic flags
    step("add_ovf",   32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b1);
    step("sub_zero",  32'd5,        32'd5,        4'b0110, 32'h00000000, 1'b1, 1'b0);
    step("sub_ovf",   32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
    step("add_wrap",  32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b0);
    step("sub_ovf2",  32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0110, 32'h80000000, 1'b0, 1'b1);
    step("add_neg",   32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0010, 32'hFFFFFFFB, 1'b0, 1'b0);

    // Mid-operation asynchronous reset between edges
    rst = 1'b1;
    #1;
    check_all("async_rst", 32'd0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;

    // Compares
    step("slt_neg",   32'hFFFFFFFF, 32'd1,        4'b0111, 32'd1, 1'b0, 1'b0);
    step("sltu_big",  32'hFFFFFFFF, 32'd1,        4'b0100, 32'd0, 1'b1, 1'b0);
    step("sltu_small",32'd1,        32'hFFFFFFFF, 4'b0100, 32'd1, 1'b0, 1'b0);
    step("slt_pos",   32'd1,        32'hFFFFFFFF, 4'b0111, 32'd0, 1'b1, 1'b0);
    step("seq_eq",    32'd9,        32'd9,        4'b1110, 32'd1, 1'b0, 1'b0);
    step("seq_ne",    32'd9,        32'd8,        4'b1110, 32'd0, 1'b1, 1'b0);

    // Shifts
    step("sra",       32'h80000000, 32'h00000024, 4'b1010, 32'hF8000000, 1'b0, 1'b0);
    step("srl",       32'h80000000, 32'h00000024, 4'b1001, 32'h08000000, 1'b0, 1'b0);
    step("sll_sh0",   32'h00000001, 32'hFFFFFFE0, 4'b1000, 32'h00000001, 1'b0, 1'b0);
    step("sll_31",    32'h00000001, 32'h0000001F, 4'b1000, 32'h80000000, 1'b0, 1'b0);
    step("sra_pos",   32'h40000000, 32'h00000004, 4'b1010, 32'h04000000, 1'b0, 1'b0);

    // Logic and misc
    step("and",       32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 1'b0, 1'b0);
    step("or",        32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0);
    step("xor",       32'hF0F0F0F0, 32'hFF00FF00, 4'b0011, 32'h0FF00FF0, 1'b0, 1'b0);
    step("nor",       32'h00000000, 32'h00000000, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0);
    step("passb",     32'h00000001, 32'hDEADBEEF, 4'b0101, 32'hDEADBEEF, 1'b0, 1'b0);
    step("lui",       32'hFFFFFFFF, 32'h00001234, 4'b1011, 32'h12340000, 1'b0, 1'b0);
    step("mul_wrap",  32'h00010000, 32'h00010000, 4'b1101, 32'h00000000, 1'b1, 1'b0);
    step("mul_neg",   32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1101, 32'h00000001, 1'b0, 1'b0);
    step("mul_big",   32'h7FFFFFFF, 32'h00000002, 4'b1101, 32'hFFFFFFFE, 1'b0, 1'b0);
    step("rsvd",      32'd5,        32'd7,        4'b1111, 32'h00000000, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
